// File: rtl/btb_assoc_pkg.sv
// rtl/btb_assoc_pkg.sv - shared types and constants for the branch target buffer
package btb_assoc_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  btb_counter_t;

    localparam btb_counter_t BTB_CNT_INIT = 2'b10;
    localparam btb_counter_t BTB_CNT_MAX  = 2'b11;
    localparam btb_counter_t BTB_CNT_MIN  = 2'b00;

    typedef enum logic {
        BTB_INIT,
        BTB_RUN
    } btb_state_e;

    // Saturating 2-bit direction counter step
    function automatic btb_counter_t btb_cnt_step(input btb_counter_t cnt, input logic taken);
        if (taken) begin
            return (cnt == BTB_CNT_MAX) ? cnt : cnt + 2'd1;
        end
        return (cnt == BTB_CNT_MIN) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/btb_assoc_plru.sv
// rtl/btb_assoc_plru.sv - tree pseudo-LRU touch and victim selection (combinational)
module btb_plru #(
    parameter int WAYS     = 4,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]     tree,
    input  logic [WAY_BITS-1:0] touch_way,
    output logic [WAYS-2:0]     tree_next,
    output logic [WAY_BITS-1:0] victim
);

    // Heap layout: node n (root = 1) lives in bit n-1; a bit of 1 points right.
    always_comb begin
        int node;
        node      = 1;
        tree_next = tree;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            tree_next[node-1] = ~touch_way[WAY_BITS-1-lvl];
            node = 2 * node + (touch_way[WAY_BITS-1-lvl] ? 1 : 0);
        end
    end

    always_comb begin
        int vnode;
        vnode = 1;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            vnode = 2 * vnode + (tree[vnode-1] ? 1 : 0);
        end
        victim = WAY_BITS'(vnode - WAYS);
    end

endmodule

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer with 2-bit counters and tree PLRU
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int SETS     = 64,
    parameter int IDX_BITS = $clog2(SETS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    output logic        ready,
    input  logic [15:0] lookup_pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [15:0] target,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target
);

    localparam int TAG_BITS = 15 - IDX_BITS;
    localparam int WAY_BITS = $clog2(WAYS);

    btb_state_e          state;
    logic [IDX_BITS-1:0] sweep_ptr;

    logic                valid_q [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    btb_counter_t        cnt_q   [SETS][WAYS];
    lc3b_word            tgt_q   [SETS][WAYS];
    logic [WAYS-2:0]     plru_q  [SETS];

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic [WAYS-1:0]     lk_match, up_match, up_way_valid;

    assign lk_idx = lookup_pc[IDX_BITS:1];
    assign lk_tag = lookup_pc[15:IDX_BITS+1];
    assign up_idx = upd_pc[IDX_BITS:1];
    assign up_tag = upd_pc[15:IDX_BITS+1];

    logic unused_pc_lsb;
    assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

    genvar gw;
    generate
        for (gw = 0; gw < WAYS; gw++) begin : g_way
            assign lk_match[gw]     = valid_q[lk_idx][gw] && (tag_q[lk_idx][gw] == lk_tag);
            assign up_match[gw]     = valid_q[up_idx][gw] && (tag_q[up_idx][gw] == up_tag);
            assign up_way_valid[gw] = valid_q[up_idx][gw];
        end
    endgenerate

    // At most one way matches, so the last match seen is the only one.
    logic     lk_hit, lk_pred;
    lc3b_word lk_tgt;

    always_comb begin
        lk_hit  = 1'b0;
        lk_pred = 1'b0;
        lk_tgt  = 16'h0000;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_match[w]) begin
                lk_hit  = 1'b1;
                lk_pred = cnt_q[lk_idx][w][1];
                lk_tgt  = tgt_q[lk_idx][w];
            end
        end
    end

    assign hit           = ready & lk_hit;
    assign predict_taken = ready & lk_pred;
    assign target        = ready ? lk_tgt : 16'h0000;

    logic                up_hit, free_found;
    logic [WAY_BITS-1:0] up_way, free_way, victim_way, touch_way;
    logic [WAYS-2:0]     plru_next;

    always_comb begin
        up_hit     = 1'b0;
        up_way     = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (up_match[w]) begin
                up_hit = 1'b1;
                up_way = WAY_BITS'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!up_way_valid[w]) begin
                free_found = 1'b1;
                free_way   = WAY_BITS'(w);
            end
        end
    end

    // Allocation prefers the lowest free way and only falls back to the tree victim.
    assign touch_way = up_hit ? up_way : (free_found ? free_way : victim_way);

    btb_plru #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_plru (
        .tree      (plru_q[up_idx]),
        .touch_way (touch_way),
        .tree_next (plru_next),
        .victim    (victim_way)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= BTB_INIT;
            sweep_ptr <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                BTB_INIT: begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[sweep_ptr][w] <= 1'b0;
                        cnt_q[sweep_ptr][w]   <= BTB_CNT_MIN;
                    end
                    plru_q[sweep_ptr] <= '0;
                    sweep_ptr         <= sweep_ptr + 1'b1;
                    if (sweep_ptr == IDX_BITS'(SETS - 1)) begin
                        state <= BTB_RUN;
                        ready <= 1'b1;
                    end
                end
                BTB_RUN: begin
                    if (upd_valid) begin
                        if (up_hit) begin
                            cnt_q[up_idx][up_way] <= btb_cnt_step(cnt_q[up_idx][up_way], upd_taken);
                            if (upd_taken) begin
                                tgt_q[up_idx][up_way] <= upd_target;
                            end
                            plru_q[up_idx] <= plru_next;
                        end else if (upd_taken) begin
                            valid_q[up_idx][touch_way] <= 1'b1;
                            tag_q[up_idx][touch_way]   <= up_tag;
                            cnt_q[up_idx][touch_way]   <= BTB_CNT_INIT;
                            tgt_q[up_idx][touch_way]   <= upd_target;
                            plru_q[up_idx]             <= plru_next;
                        end
                    end
                end
                default: begin
                    state <= BTB_INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
